paged_address_sequencer: RTL and testbench

Generates the stream of page addresses consumed by the paged memory reader. A command (base address plus page count) goes in, and one address per page comes out, with `m_axis_tlast` set on the final page of the command. The block also watches the reader's output data stream so it can report when each command has fully completed. It sits between the command/display controller and the paged memory reader.

---
 rtl/paged_address_sequencer.sv | 152 +++++++++++++++
 tb/tb_paged_address_sequencer.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/paged_address_sequencer.sv
// Paged address sequencer: queues {page_count, base} commands and emits one
// 128-byte-aligned page address per page, tracking completion via the reader's tlast.
module paged_address_sequencer #(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned COUNT_WIDTH = 16,
    parameter int unsigned PAGE_SIZE   = 2048,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic                              aclk,
    input  logic                              reset,
    input  logic                              s_cmd_tvalid,
    output logic                              s_cmd_tready,
    input  logic [ADDR_WIDTH+COUNT_WIDTH-1:0] s_cmd_tdata,
    output logic                              m_axis_tvalid,
    input  logic                              m_axis_tready,
    output logic                              m_axis_tlast,
    output logic [31:0]                       m_axis_tdata,
    input  logic                              s_mon_tvalid,
    input  logic                              s_mon_tlast,
    output logic                              busy,
    output logic                              cmd_done
);

    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned PEND_W = $clog2(FIFO_DEPTH + 2) + 1;
    localparam int unsigned CMD_W  = ADDR_WIDTH + COUNT_WIDTH;

    localparam logic [CNT_W-1:0]      DEPTH      = CNT_W'(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] PAGE_INC   = ADDR_WIDTH'(PAGE_SIZE);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = {{(ADDR_WIDTH-7){1'b1}}, 7'b0};

    typedef enum logic {
        IDLE,
        EMIT
    } state_t;

    state_t state, state_next;

    logic [CMD_W-1:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr, rd_ptr;
    logic [CNT_W-1:0]       fifo_cnt, fifo_cnt_next;
    logic                   head_fresh;
    logic                   push, pop;

    logic [ADDR_WIDTH-1:0]  head_base;
    logic [COUNT_WIDTH-1:0] head_count;
    logic [ADDR_WIDTH-1:0]  cur, cur_next;
    logic [COUNT_WIDTH-1:0] remaining, remaining_next;

    logic                   last_hs, mon_last;
    logic [PEND_W-1:0]      pending;

    assign push                    = s_cmd_tvalid & s_cmd_tready;
    assign {head_count, head_base} = mem[rd_ptr];
    assign m_axis_tdata            = 32'(cur);
    assign last_hs                 = m_axis_tvalid & m_axis_tready & m_axis_tlast;
    assign mon_last                = s_mon_tvalid & s_mon_tlast & (pending != '0);
    assign busy                    = (fifo_cnt != '0) | (state != IDLE) | (pending != '0);

    always_comb begin
        fifo_cnt_next = fifo_cnt;
        if (push && !pop) begin
            fifo_cnt_next = fifo_cnt + CNT_W'(1);
        end else if (pop && !push) begin
            fifo_cnt_next = fifo_cnt - CNT_W'(1);
        end
    end

    // A head entry written on the previous edge is held back one cycle, which
    // gives the two-edge command-to-address latency while keeping a single
    // idle cycle between back-to-back queued commands.
    always_comb begin
        state_next     = state;
        pop            = 1'b0;
        cur_next       = cur;
        remaining_next = remaining;
        m_axis_tvalid  = 1'b0;
        m_axis_tlast   = 1'b0;
        case (state)
            IDLE: begin
                if (fifo_cnt != '0 && !head_fresh) begin
                    pop = 1'b1;
                    if (head_count != '0) begin
                        cur_next       = head_base & ALIGN_MASK;
                        remaining_next = head_count;
                        state_next     = EMIT;
                    end
                end
            end
            EMIT: begin
                m_axis_tvalid = 1'b1;
                m_axis_tlast  = (remaining == COUNT_WIDTH'(1));
                if (m_axis_tready) begin
                    cur_next       = cur + PAGE_INC;
                    remaining_next = remaining - COUNT_WIDTH'(1);
                    if (m_axis_tlast) begin
                        state_next = IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge aclk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_cnt     <= '0;
            head_fresh   <= 1'b0;
            s_cmd_tready <= 1'b0;
            cur          <= '0;
            remaining    <= '0;
        end else begin
            state        <= state_next;
            cur          <= cur_next;
            remaining    <= remaining_next;
            fifo_cnt     <= fifo_cnt_next;
            s_cmd_tready <= (fifo_cnt_next < DEPTH);
            head_fresh   <= push && ((fifo_cnt == '0) || (pop && fifo_cnt == CNT_W'(1)));
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (push) begin
            mem[wr_ptr] <= s_cmd_tdata;
        end
    end

    // Monitor tlast with nothing outstanding is dropped rather than underflowing.
    always_ff @(posedge aclk or posedge reset) begin
        if (reset) begin
            pending  <= '0;
            cmd_done <= 1'b0;
        end else begin
            cmd_done <= mon_last;
            case ({last_hs, mon_last})
                2'b10:   pending <= pending + PEND_W'(1);
                2'b01:   pending <= pending - PEND_W'(1);
                default: pending <= pending;
            endcase
        end
    end

endmodule

// File: tb/tb_paged_address_sequencer.sv
// Directed plus randomized bench for paged_address_sequencer, scored against a
// page-list/outstanding-count reference model.
module tb_paged_address_sequencer;

    localparam int unsigned AW   = 32;
    localparam int unsigned CW   = 16;
    localparam int unsigned PAGE = 2048;

    logic          aclk;
    logic          reset;
    logic          s_cmd_tvalid;
    logic          s_cmd_tready;
    logic [AW+CW-1:0] s_cmd_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic          m_axis_tlast;
    logic [31:0]   m_axis_tdata;
    logic          s_mon_tvalid;
    logic          s_mon_tlast;
    logic          busy;
    logic          cmd_done;

    paged_address_sequencer #(
        .ADDR_WIDTH (AW),
        .COUNT_WIDTH(CW),
        .PAGE_SIZE  (PAGE),
        .FIFO_DEPTH (4)
    ) dut (
        .aclk         (aclk),
        .reset        (reset),
        .s_cmd_tvalid (s_cmd_tvalid),
        .s_cmd_tready (s_cmd_tready),
        .s_cmd_tdata  (s_cmd_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tlast (m_axis_tlast),
        .m_axis_tdata (m_axis_tdata),
        .s_mon_tvalid (s_mon_tvalid),
        .s_mon_tlast  (s_mon_tlast),
        .busy         (busy),
        .cmd_done     (cmd_done)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    typedef struct {
        logic [31:0] addr;
        logic        last;
    } beat_t;

    beat_t       exp_q[$];
    int unsigned pending_m;
    logic        done_exp;
    logic        stall_prev;
    logic [31:0] held_data;
    logic        held_last;
    logic        cmd_hs;
    int unsigned n_beats;
    int unsigned n_checks;
    int unsigned n_pass;
    int unsigned n_fail;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Expected page list: aligned base plus i pages, 32-bit wrap.
    task automatic model_cmd(input logic [31:0] base, input logic [15:0] cnt);
        beat_t       b;
        logic [31:0] aligned;
        aligned = base & 32'hFFFF_FF80;
        for (int unsigned i = 0; i < 32'(cnt); i++) begin
            b.addr = aligned + i * PAGE;
            b.last = (i + 1 == 32'(cnt));
            exp_q.push_back(b);
        end
    endtask

    task automatic model_flush();
        exp_q.delete();
        pending_m  = 0;
        done_exp   = 1'b0;
        stall_prev = 1'b0;
    endtask

    task automatic tick();
        beat_t b;
        logic  beat_hs, mon;
        @(negedge aclk);
        check("cmd_done", 32'(cmd_done), 32'(done_exp));
        if (stall_prev) begin
            check("hold_valid", 32'(m_axis_tvalid), 32'd1);
            check("hold_data", m_axis_tdata, held_data);
            check("hold_last", 32'(m_axis_tlast), 32'(held_last));
        end
        stall_prev = m_axis_tvalid && !m_axis_tready;
        held_data  = m_axis_tdata;
        held_last  = m_axis_tlast;
        cmd_hs     = s_cmd_tvalid && s_cmd_tready;
        beat_hs    = m_axis_tvalid && m_axis_tready;
        mon        = s_mon_tvalid && s_mon_tlast && (pending_m > 0);
        if (mon) pending_m--;
        done_exp = mon;
        if (beat_hs) begin
            n_beats++;
            check("beat_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                b = exp_q.pop_front();
                check("beat_addr", m_axis_tdata, b.addr);
                check("beat_last", 32'(m_axis_tlast), 32'(b.last));
                if (b.last) pending_m++;
            end
        end
        if (cmd_hs) model_cmd(s_cmd_tdata[31:0], s_cmd_tdata[47:32]);
        @(posedge aclk);
        #1;
    endtask

    task automatic push_cmd(input logic [31:0] base, input logic [15:0] cnt);
        int unsigned n;
        s_cmd_tvalid = 1'b1;
        s_cmd_tdata  = {cnt, base};
        n = 0;
        do begin
            tick();
            n++;
        end while (!cmd_hs && n < 20);
        check("cmd_accept_timeout", 32'(cmd_hs), 32'd1);
        s_cmd_tvalid = 1'b0;
    endtask

    task automatic wait_valid(output int unsigned n);
        n = 0;
        while (!m_axis_tvalid && n < 50) begin
            tick();
            n++;
        end
    endtask

    task automatic drain();
        int unsigned n;
        m_axis_tready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            tick();
            n++;
        end
        check("drain_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic retire_all();
        int unsigned n;
        s_mon_tvalid = 1'b1;
        s_mon_tlast  = 1'b1;
        n = 0;
        while (pending_m > 0 && n < 50) begin
            tick();
            n++;
        end
        s_mon_tvalid = 1'b0;
        s_mon_tlast  = 1'b0;
        tick();
    endtask

    int unsigned       n, b0;
    logic [31:0]       cmd_base [7];
    logic [15:0]       cmd_cnt  [7];
    logic [6:0]        bp_pat;

    initial begin
        reset = 1'b1;
        s_cmd_tvalid = 1'b0;
        s_cmd_tdata  = '0;
        m_axis_tready = 1'b0;
        s_mon_tvalid = 1'b0;
        s_mon_tlast  = 1'b0;
        n_checks = 0; n_pass = 0; n_fail = 0; n_beats = 0;
        cmd_hs = 1'b0; held_data = '0; held_last = 1'b0;
        model_flush();

        // Reset values and tready rise after release
        repeat (3) tick();
        check("rst_cmd_tready", 32'(s_cmd_tready), 32'd0);
        check("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("rst_tlast", 32'(m_axis_tlast), 32'd0);
        check("rst_tdata", m_axis_tdata, 32'd0);
        check("rst_cmd_done", 32'(cmd_done), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        check("tready_before_edge", 32'(s_cmd_tready), 32'd0);
        tick();
        check("tready_after_edge", 32'(s_cmd_tready), 32'd1);

        // Basic command
        m_axis_tready = 1'b1;
        push_cmd(32'h1000_0040, 16'd3);
        wait_valid(n);
        check("basic_latency", n, 32'd2);
        check("basic_first_addr", m_axis_tdata, 32'h1000_0000);
        b0 = n_beats;
        repeat (3) tick();
        check("basic_beats", n_beats - b0, 32'd3);
        check("basic_valid_low", 32'(m_axis_tvalid), 32'd0);
        retire_all();

        // Backpressure
        push_cmd(32'h1000_0040, 16'd3);
        wait_valid(n);
        check("bp_valid_timeout", 32'(n < 50), 32'd1);
        bp_pat = 7'b1001001;
        b0 = n_beats;
        for (int unsigned k = 0; k < 7; k++) begin
            m_axis_tready = bp_pat[6 - k];
            tick();
        end
        check("bp_beats", n_beats - b0, 32'd3);
        check("bp_valid_low", 32'(m_axis_tvalid), 32'd0);
        retire_all();

        // Zero-count command then FIFO fill with the output stalled
        m_axis_tready = 1'b0;
        cmd_base = '{32'h2000_0000, 32'h2000_1000, 32'h2100_00FF, 32'h2200_0080,
                     32'h2300_0000, 32'h2400_0800, 32'h2500_0000};
        cmd_cnt  = '{16'd0, 16'd1, 16'd2, 16'd1, 16'd3, 16'd1, 16'd2};
        for (int unsigned k = 0; k < 6; k++) push_cmd(cmd_base[k], cmd_cnt[k]);
        check("full_tready_low", 32'(s_cmd_tready), 32'd0);
        s_cmd_tvalid = 1'b1;
        s_cmd_tdata  = {cmd_cnt[6], cmd_base[6]};
        n = 0;
        do begin
            tick();
            n++;
        end while (!cmd_hs && n < 6);
        check("full_blocks_push", 32'(cmd_hs), 32'd0);
        check("full_tready_held", 32'(s_cmd_tready), 32'd0);
        m_axis_tready = 1'b1;
        n = 0;
        while (!s_cmd_tready && n < 20) begin
            tick();
            n++;
        end
        check("full_tready_rise", 32'(s_cmd_tready), 32'd1);
        do tick(); while (!cmd_hs && n++ < 40);
        s_cmd_tvalid = 1'b0;
        drain();
        retire_all();

        // Address wrap-around
        push_cmd(32'hFFFF_F800, 16'd2);
        wait_valid(n);
        check("wrap_addr0", m_axis_tdata, 32'hFFFF_F800);
        check("wrap_last0", 32'(m_axis_tlast), 32'd0);
        tick();
        check("wrap_addr1", m_axis_tdata, 32'h0000_0000);
        check("wrap_last1", 32'(m_axis_tlast), 32'd1);
        tick();
        retire_all();

        // Completion tracking
        push_cmd(32'h0400_0000, 16'd1);
        push_cmd(32'h0500_0000, 16'd1);
        drain();
        repeat (2) tick();
        check("done_busy_pending", 32'(busy), 32'd1);
        s_mon_tvalid = 1'b1; s_mon_tlast = 1'b1;
        tick();
        s_mon_tvalid = 1'b0; s_mon_tlast = 1'b0;
        check("done_pulse_t1", 32'(cmd_done), 32'd1);
        check("done_busy_t1", 32'(busy), 32'd1);
        tick();
        check("done_low_t2", 32'(cmd_done), 32'd0);
        tick();
        s_mon_tvalid = 1'b1; s_mon_tlast = 1'b1;
        tick();
        check("done_pulse_t4", 32'(cmd_done), 32'd1);
        check("done_busy_t4", 32'(busy), 32'd0);
        tick();
        s_mon_tvalid = 1'b0; s_mon_tlast = 1'b0;
        check("done_spurious", 32'(cmd_done), 32'd0);
        check("done_busy_idle", 32'(busy), 32'd0);
        tick();

        // Reset during the second page with two commands queued
        m_axis_tready = 1'b0;
        push_cmd(32'h0600_0000, 16'd4);
        push_cmd(32'h0700_0000, 16'd2);
        push_cmd(32'h0800_0000, 16'd2);
        wait_valid(n);
        m_axis_tready = 1'b1;
        tick();
        m_axis_tready = 1'b0;
        tick();
        check("mid_second_page", m_axis_tdata, 32'h0600_0800);
        #2;
        reset = 1'b1;
        #1;
        model_flush();
        check("mid_rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("mid_rst_tlast", 32'(m_axis_tlast), 32'd0);
        check("mid_rst_tdata", m_axis_tdata, 32'd0);
        check("mid_rst_cmd_tready", 32'(s_cmd_tready), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        repeat (2) tick();
        reset = 1'b0;
        m_axis_tready = 1'b1;
        b0 = n_beats;
        repeat (8) tick();
        check("mid_no_residual", n_beats - b0, 32'd0);
        check("mid_idle_busy", 32'(busy), 32'd0);
        push_cmd(32'h3000_0100, 16'd2);
        wait_valid(n);
        check("mid_new_addr", m_axis_tdata, 32'h3000_0100);
        check("mid_new_last", 32'(m_axis_tlast), 32'd0);
        drain();
        retire_all();

        // Randomized traffic
        s_cmd_tvalid = 1'b0;
        for (int unsigned c = 0; c < 600; c++) begin
            if (!s_cmd_tvalid || cmd_hs) begin
                s_cmd_tvalid = 1'b0;
                if (pending_m < 6 && $urandom_range(0, 2) == 0) begin
                    s_cmd_tvalid = 1'b1;
                    s_cmd_tdata  = {16'($urandom_range(0, 5)), $urandom};
                end
            end
            m_axis_tready = ($urandom_range(0, 3) != 0);
            s_mon_tvalid  = ($urandom_range(0, 1) == 1);
            s_mon_tlast   = s_mon_tvalid && (pending_m > 0) && ($urandom_range(0, 1) == 1);
            tick();
        end
        s_cmd_tvalid = 1'b0;
        s_mon_tvalid = 1'b0;
        s_mon_tlast  = 1'b0;
        drain();
        repeat (4) tick();
        retire_all();
        repeat (2) tick();
        check("final_busy", 32'(busy), 32'd0);
        check("final_queue", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
